pressurize: RTL and testbench
=============================

PRESSURIZE -- requirements
Module: pressurize

Interface
REQ-001 SHALL have parameter FILL_CYCLES, default 16, the number of valve-open cycles needed to reach full pressure (legal range 2..2^CNT_W).
REQ-002 SHALL have parameter CNT_W, default 5, the fill-counter width.
REQ-003 SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port begin_Pressurization, input, 1 bit: operator request, held high for the whole fill.
REQ-006 SHALL have port InnerClosed, input, 1 bit: 1 = inner door sealed.
REQ-007 SHALL have port OuterClosed, input, 1 bit: 1 = outer door sealed.
REQ-008 SHALL have port Evacuation, input, 1 bit: evacuation pump active (interlock from the evacuate controller).
REQ-009 SHALL have port Evacuated, input, 1 bit: chamber-at-vacuum status from the evacuate side.
REQ-010 SHALL have port Pressurization, output, 1 bit: fill valve open.
REQ-011 SHALL have port Pressurized, output, 1 bit: chamber at full pressure; consumed by the evacuate controller.
REQ-012 SHALL have port Fault, output, 1 bit: interlock violation latched.

Function
REQ-013 SHALL implement a Moore FSM with states EMPTY, FILLING, FULL and FAULT (plus PAUSED under REQ-027); all outputs are decoded from registered state only.
REQ-014 Output decode SHALL be: EMPTY 0/0/0; FILLING Pressurization=1; FULL Pressurized=1; FAULT Fault=1; PAUSED all 0 (order Pressurization/Pressurized/Fault).
REQ-015 In EMPTY, begin_Pressurization=1 && InnerClosed && OuterClosed && !Evacuation SHALL cause a transition to FILLING with the counter cleared to 0; otherwise the FSM SHALL stay in EMPTY.
REQ-016 In FILLING, priority per cycle SHALL be: Evacuation=1 -> FAULT; then any door open -> FAULT (or PAUSED per REQ-027); then begin_Pressurization=0 -> EMPTY; then counter==FILL_CYCLES-1 -> FULL; else counter increments by 1.
REQ-017 Latency: a request sampled at edge t SHALL give Pressurization=1 from t+1 for exactly FILL_CYCLES cycles and Pressurized=1 from t+1+FILL_CYCLES.
REQ-018 The counter SHALL never wrap; it is compared before incrementing and is held at 0 outside FILLING/PAUSED.
REQ-019 In FULL, OuterClosed=0 (venting) or Evacuated=1 SHALL cause a transition to EMPTY; otherwise the FSM SHALL stay in FULL regardless of begin_Pressurization.
REQ-020 In FAULT, the FSM SHALL go to EMPTY when begin_Pressurization=0 (operator acknowledge); otherwise it SHALL stay in FAULT.
REQ-021 A door opening in the same cycle as the counter reaching FILL_CYCLES-1 SHALL follow the door rule, not completion.
REQ-022 Pressurization and Evacuation-driven states SHALL never overlap: Pressurization SHALL be low in the cycle after Evacuation is sampled high.

Reset
REQ-023 Reset=1 at a rising edge SHALL force EMPTY, counter=0, Pressurization=0, Pressurized=0 and Fault=0.
REQ-024 Reset SHALL override every transition, including mid-FILLING, PAUSED and FAULT; partial fill progress is discarded.
REQ-025 On the first edge with Reset=0, FSM evaluation SHALL start from EMPTY.

Configuration
REQ-026 Macro PRESSURIZE_PAUSE_EN SHALL select the door-open behaviour during a fill.
REQ-027 With PRESSURIZE_PAUSE_EN defined: a door open in FILLING SHALL go to PAUSED with the counter held; in PAUSED, Evacuation=1 -> FAULT; else begin_Pressurization=0 -> EMPTY; else both doors closed -> FILLING, resuming from the held count; else stay PAUSED.
REQ-028 Without PRESSURIZE_PAUSE_EN: the PAUSED state SHALL not exist, and a door open in FILLING SHALL go to FAULT.

Verification
REQ-029 Scenario 1: FILL_CYCLES=4, doors closed, begin=1 at edge 0 -> Pressurization=1 on cycles 1-4, Pressurized=1 from cycle 5, Fault=0 throughout.
REQ-030 Scenario 2: fill in progress at count 2, InnerClosed=0 for 1 cycle, macro off -> Fault=1 next cycle; begin=0 -> EMPTY, all outputs 0.
REQ-031 Scenario 3: same stimulus with the macro on -> PAUSED, all outputs 0, count held at 2; doors closed -> 2 more FILLING cycles, then Pressurized=1.
REQ-032 Scenario 4: Evacuation=1 during FILLING -> Fault=1 next cycle and Pressurization=0 in that same cycle, in both configurations.
REQ-033 Scenario 5: in FULL, Evacuated=1 -> Pressurized=0 next cycle; separately OuterClosed=0 in FULL -> EMPTY.
REQ-034 Scenario 6: Reset=1 at count 3 of FILLING -> all outputs 0 next cycle; a new request then takes the full FILL_CYCLES again.

Source files
------------

// File: rtl/pressurize.sv
// pressurize: airlock fill controller (EMPTY -> FILLING -> FULL, FAULT on interlock violation).
// Define PRESSURIZE_PAUSE_EN to pause the fill on a door opening instead of faulting.
module pressurize #(
  parameter int FILL_CYCLES = 16,
  parameter int CNT_W = 5
) (
  input  logic Clock,
  input  logic Reset,
  input  logic begin_Pressurization,
  input  logic InnerClosed,
  input  logic OuterClosed,
  input  logic Evacuation,
  input  logic Evacuated,
  output logic Pressurization,
  output logic Pressurized,
  output logic Fault
);
`ifdef PRESSURIZE_PAUSE_EN
  typedef enum logic [2:0] {EMPTY, FILLING, FULL, FAULT, PAUSED} state_t;
`else
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, FAULT} state_t;
`endif
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic doors, done;
  assign doors = InnerClosed && OuterClosed;
  assign done = cnt == CNT_W'(FILL_CYCLES - 1);
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= EMPTY;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  end
  // counter compares before incrementing, so it tops out at FILL_CYCLES-1 and never wraps
  always_comb begin
    state_nxt = state;
    cnt_nxt = '0;
    case (state)
      EMPTY: if (begin_Pressurization && doors && !Evacuation) state_nxt = FILLING;
      FILLING:
        if (Evacuation) state_nxt = FAULT;
        else if (!doors) begin
`ifdef PRESSURIZE_PAUSE_EN
          state_nxt = PAUSED;
          cnt_nxt = cnt;
`else
          state_nxt = FAULT;
`endif
        end
        else if (!begin_Pressurization) state_nxt = EMPTY;
        else if (done) state_nxt = FULL;
        else cnt_nxt = cnt + 1'b1;
      FULL: if (!OuterClosed || Evacuated) state_nxt = EMPTY;
      FAULT: if (!begin_Pressurization) state_nxt = EMPTY;
`ifdef PRESSURIZE_PAUSE_EN
      PAUSED:
        if (Evacuation) state_nxt = FAULT;
        else if (!begin_Pressurization) state_nxt = EMPTY;
        else begin
          state_nxt = doors ? FILLING : PAUSED;
          cnt_nxt = cnt;
        end
`endif
      default: state_nxt = EMPTY;
    endcase
  end
  always_comb begin
    Pressurization = state == FILLING;
    Pressurized = state == FULL;
    Fault = state == FAULT;
  end
endmodule

// File: tb/tb_pressurize.sv
// tb_pressurize: vector table plus hand sequences, expected outputs queued and checked after each edge.
module tb_pressurize;
  logic Clock = 0, Reset, begin_Pressurization, InnerClosed, OuterClosed, Evacuation, Evacuated;
  logic Pressurization, Pressurized, Fault;
  typedef struct {
    logic [5:0] in;
    logic [2:0] exp;
  } vec_t;
  // input packing {Reset, begin, InnerClosed, OuterClosed, Evacuation, Evacuated}
  localparam logic [5:0] RST = 6'b111100, IDLE = 6'b001100, GO = 6'b011100, GO_IN_OPEN = 6'b010100,
    GO_OUT_OPEN = 6'b011000, GO_EV = 6'b011110, IDLE_EVD = 6'b001101, OPEN_IDLE = 6'b000100;
  // output packing {Pressurization, Pressurized, Fault}
  localparam logic [2:0] O0 = 3'b000, OP = 3'b100, OD = 3'b010, OF = 3'b001;
`ifdef PRESSURIZE_PAUSE_EN
  localparam logic [2:0] ODOOR = O0;
`else
  localparam logic [2:0] ODOOR = OF;
`endif
  vec_t vecs[$];
  logic [2:0] sb[$];
  int applied = 0, errors = 0;

  pressurize #(.FILL_CYCLES(4), .CNT_W(5)) dut (
    .Clock(Clock), .Reset(Reset), .begin_Pressurization(begin_Pressurization),
    .InnerClosed(InnerClosed), .OuterClosed(OuterClosed), .Evacuation(Evacuation),
    .Evacuated(Evacuated), .Pressurization(Pressurization), .Pressurized(Pressurized), .Fault(Fault)
  );

  always #5 Clock = ~Clock;

  task automatic add(input logic [5:0] i, input logic [2:0] e, input int n = 1);
    for (int k = 0; k < n; k++) vecs.push_back('{in: i, exp: e});
  endtask

  task automatic step(input logic [5:0] i, input logic [2:0] e, input string name);
    logic [2:0] want, got;
    {Reset, begin_Pressurization, InnerClosed, OuterClosed, Evacuation, Evacuated} = i;
    sb.push_back(e);
    @(posedge Clock);
    #1;
    want = sb.pop_front();
    got = {Pressurization, Pressurized, Fault};
    applied++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: outputs P/Pd/F got %b expected %b", name, got, want);
    end
  endtask

  initial begin
    add(RST, O0, 2);
    add(GO, OP, 4);
    add(GO, OD, 2);
    add(IDLE, OD);
    add(IDLE_EVD, O0);
    add(IDLE, O0);
    add(GO_IN_OPEN, O0);
    add(GO_EV, O0);
    add(GO, OP, 3);
    add(GO_IN_OPEN, ODOOR);
`ifdef PRESSURIZE_PAUSE_EN
    add(GO, OP, 2);
    add(GO, OD);
    add(GO_OUT_OPEN, O0);
`else
    add(GO, OF);
    add(IDLE, O0);
`endif
    add(GO, OP, 4);
    add(GO, OD);
    add(GO_OUT_OPEN, O0);
    add(IDLE, O0);
    add(GO, OP, 2);
    add(GO_EV, OF, 2);
    add(IDLE, O0);
    add(GO, OP);
    add(GO_EV, OF);
    add(RST, O0);
    add(IDLE, O0);
    add(GO, OP, 4);
    add(GO_OUT_OPEN, ODOOR);
    add(IDLE, O0);
`ifdef PRESSURIZE_PAUSE_EN
    add(GO, OP, 2);
    add(GO_IN_OPEN, O0);
    add(GO_EV, OF);
    add(IDLE, O0);
    add(GO, OP);
    add(GO_IN_OPEN, O0);
    add(OPEN_IDLE, O0);
    add(GO, OP, 4);
    add(GO, OD);
    add(IDLE_EVD, O0);
`endif
    for (int v = 0; v < vecs.size(); v++) step(vecs[v].in, vecs[v].exp, $sformatf("vec%0d", v));
    for (int k = 0; k < 4; k++) step(GO, OP, $sformatf("rst_fill%0d", k));
    step(RST, O0, "rst_midfill");
    for (int k = 0; k < 4; k++) step(GO, OP, $sformatf("refill%0d", k));
    step(GO, OD, "refill_full");
    step(IDLE_EVD, O0, "refill_vent");
    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end
endmodule
